// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM
// encodings and small op-decode helpers.
package hilo_muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MADDU = 3'd5;
  localparam logic [2:0] OP_MSUB  = 3'd6;
  localparam logic [2:0] OP_MSUBU = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Even codes are the signed variants.
  function automatic logic op_is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/hilo_muldiv_divider.sv
// Serial restoring unsigned divider: one quotient bit per step, WIDTH steps.
// Operands are captured on start; sign and special cases are handled by the caller.
module hilo_muldiv_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   diff_s;

  // Next-state for one restoring iteration; bit WIDTH of diff is the borrow.
  always_comb begin
    shifted_s = {rem_q, quo_q[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, div_q};
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    if (start) begin
      rem_d = {WIDTH{1'b0}};
      quo_d = dividend;
      div_d = divisor;
    end else if (step) begin
      if (!diff_s[WIDTH]) begin
        rem_d = diff_s[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted_s[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      rem_d = rem_q;
    end
  end

  // Divider state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem_q <= {WIDTH{1'b0}};
      quo_q <= {WIDTH{1'b0}};
      div_q <= {WIDTH{1'b0}};
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      div_q <= div_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with a multi-cycle MULT/DIV/MADD/MSUB engine,
// direct MTHI/MTLO writes and forwarded MFHI/MFLO reads.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               op_valid,
  input  logic [2:0]         op_code,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               cancel,
  output logic               busy,
  output logic               done,
  input  logic               r_hilo,
  output logic [2*WIDTH-1:0] r_data,
  input  logic               w_hi,
  input  logic [WIDTH-1:0]   hi_data,
  input  logic               w_lo,
  input  logic [WIDTH-1:0]   lo_data
);

  localparam int MAXC  = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CNT_W = $clog2(MAXC + 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] prod_pipe_q [MUL_LAT];
  logic [2*WIDTH-1:0] prod_pipe_d [MUL_LAT];

  logic               accept_s, write_s, sgn_s;
  logic [WIDTH-1:0]   hi_w_s, lo_w_s, abs_a_s, abs_b_s;
  logic [WIDTH-1:0]   quo_s, rem_s, q_fix_s, r_fix_s;
  logic [2*WIDTH-1:0] ma_s, mb_s, prod_s, res_s;

  assign accept_s = op_valid & ~busy & ~cancel;
  assign write_s  = (state_q == ST_FIX) & ~cancel;
  assign hi_w_s   = w_hi ? hi_data : hi_q;
  assign lo_w_s   = w_lo ? lo_data : lo_q;
  assign abs_a_s  = (op_is_signed(op_code) && op_a[WIDTH-1]) ? -op_a : op_a;
  assign abs_b_s  = (op_is_signed(op_code) && op_b[WIDTH-1]) ? -op_b : op_b;

  hilo_muldiv_divider #(.WIDTH(WIDTH)) u_div (
    .clock     (clock),
    .reset     (reset),
    .start     (accept_s & op_is_div(op_code)),
    .step      (state_q == ST_DIV),
    .dividend  (abs_a_s),
    .divisor   (abs_b_s),
    .quotient  (quo_s),
    .remainder (rem_s)
  );

  // FSM sequencing: MUL holds MUL_LAT cycles, DIV holds WIDTH cycles, then FIX.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (accept_s) begin
          state_d = op_is_div(op_code) ? ST_DIV : ST_MUL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (cancel) begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == ((state_q == ST_MUL) ? CNT_W'(MUL_LAT - 1) : CNT_W'(WIDTH - 1))) begin
          state_d = ST_FIX;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture; accumulate ops snapshot HI/LO including same-cycle MT* writes.
  always_comb begin
    if (accept_s) begin
      op_d  = op_code;
      a_d   = op_a;
      b_d   = op_b;
      acc_d = {hi_w_s, lo_w_s};
    end else begin
      op_d  = op_q;
      a_d   = a_q;
      b_d   = b_q;
      acc_d = acc_q;
    end
  end

  // Sign-extending to 2*WIDTH makes one unsigned multiply serve both signednesses.
  always_comb begin
    sgn_s          = op_is_signed(op_q);
    ma_s           = {{WIDTH{sgn_s & a_q[WIDTH-1]}}, a_q};
    mb_s           = {{WIDTH{sgn_s & b_q[WIDTH-1]}}, b_q};
    prod_pipe_d[0] = ma_s * mb_s;
    for (int i = 1; i < MUL_LAT; i++) begin
      prod_pipe_d[i] = prod_pipe_q[i-1];
    end
    prod_s = prod_pipe_q[MUL_LAT-1];
  end

  // FIX-stage result: sign fix-up, divide-by-zero, accumulate.
  always_comb begin
    q_fix_s = (sgn_s && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_s : quo_s;
    r_fix_s = (sgn_s && a_q[WIDTH-1]) ? -rem_s : rem_s;
    res_s   = prod_s;
    case (op_q)
      OP_MULT, OP_MULTU: res_s = prod_s;
      OP_DIV, OP_DIVU: begin
        if (b_q == {WIDTH{1'b0}}) begin
          res_s = {a_q, {WIDTH{1'b1}}};
        end else begin
          res_s = {r_fix_s, q_fix_s};
        end
      end
      OP_MADD, OP_MADDU: res_s = acc_q + prod_s;
      OP_MSUB, OP_MSUBU: res_s = acc_q - prod_s;
      default:           res_s = prod_s;
    endcase
  end

  // Direct writes are younger than the engine result and win per half.
  always_comb begin
    if (w_hi) begin
      hi_d = hi_data;
    end else if (write_s) begin
      hi_d = res_s[2*WIDTH-1:WIDTH];
    end else begin
      hi_d = hi_q;
    end
    if (w_lo) begin
      lo_d = lo_data;
    end else if (write_s) begin
      lo_d = res_s[WIDTH-1:0];
    end else begin
      lo_d = lo_q;
    end
  end

  // Architectural and engine state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      op_q    <= 3'd0;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      acc_q   <= {(2*WIDTH){1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      for (int i = 0; i < MUL_LAT; i++) begin
        prod_pipe_q[i] <= {(2*WIDTH){1'b0}};
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      for (int i = 0; i < MUL_LAT; i++) begin
        prod_pipe_q[i] <= prod_pipe_d[i];
      end
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = write_s;
  assign r_data = r_hilo ? {hi_d, lo_d} : {(2*WIDTH){1'b0}};

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: expected {HI,LO} pushed at issue,
// popped and compared when done pulses.
module tb_hilo_muldiv;

  logic        clock = 1'b0;
  logic        reset, op_valid, cancel, r_hilo, w_hi, w_lo;
  logic [2:0]  op_code;
  logic [31:0] op_a, op_b, hi_data, lo_data;
  logic        busy, done;
  logic [63:0] r_data;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [63:0] model_hilo;
  logic [63:0] sb_q[$];

  hilo_muldiv #(.WIDTH(32), .MUL_LAT(2)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .cancel(cancel), .busy(busy), .done(done),
    .r_hilo(r_hilo), .r_data(r_data), .w_hi(w_hi), .hi_data(hi_data),
    .w_lo(w_lo), .lo_data(lo_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] acc);
    longint      sa, sb;
    logic [63:0] ps, pu;
    logic [31:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ps = 64'(sa * sb);
    pu = {32'd0, a} * {32'd0, b};
    q  = 32'hFFFF_FFFF;
    r  = a;
    if (b != 32'd0) begin
      if (op == 3'd2) begin
        q = 32'(sa / sb);
        r = 32'(sa % sb);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
    case (op)
      3'd0:       return ps;
      3'd1:       return pu;
      3'd2, 3'd3: return {r, q};
      3'd4:       return acc + ps;
      3'd5:       return acc + pu;
      3'd6:       return acc - ps;
      default:    return acc - pu;
    endcase
  endfunction

  // Called at posedge+1; issues one op and waits (bounded) for its done pulse.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    int n;
    bit seen;
    int lat;
    lat = (op == 3'd2 || op == 3'd3) ? 33 : 3;
    sb_q.push_back(exp);
    op_valid = 1'b1; op_code = op; op_a = a; op_b = b;
    @(posedge clock); #1;
    op_valid = 1'b0;
    n = 1;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clock);
      if (done) begin
        seen = 1'b1;
        chk("result", r_data, sb_q.pop_front());
        chk("latency", 64'(n), 64'(lat));
      end
      @(posedge clock); #1;
      n++;
    end
    if (!seen) begin
      chk("done_timeout", 64'd0, 64'd1);
      void'(sb_q.pop_front());
    end
    chk("stored", r_data, exp);
    chk("idle_after", {63'd0, busy}, 64'd0);
    model_hilo = exp;
  endtask

  task automatic mt(input logic [31:0] h, input logic [31:0] l);
    w_hi = 1'b1; w_lo = 1'b1; hi_data = h; lo_data = l;
    @(posedge clock); #1;
    w_hi = 1'b0; w_lo = 1'b0;
    model_hilo = {h, l};
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          dc;
    reset = 1'b1; op_valid = 1'b0; cancel = 1'b0; r_hilo = 1'b1;
    w_hi = 1'b0; w_lo = 1'b0; op_code = 3'd0; op_a = 32'd0; op_b = 32'd0;
    hi_data = 32'd0; lo_data = 32'd0; model_hilo = 64'd0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_data", r_data, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Multiply sign handling
    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE);

    // Divide: signed, overflow, divide by zero
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    run_op(3'd3, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF);
    run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);

    // Accumulate
    mt(32'd0, 32'd10);
    chk("mt_read", r_data, 64'h0000_0000_0000_000A);
    run_op(3'd4, 32'd3, 32'd4, 64'h0000_0000_0000_0016);
    run_op(3'd7, 32'd1, 32'h17, 64'hFFFF_FFFF_FFFF_FFFF);

    // Cancel a DIVU at cycle 10, new MULTU in cycle 11
    dc = done_cnt;
    op_valid = 1'b1; op_code = 3'd3; op_a = 32'd100; op_b = 32'd7;
    @(posedge clock); #1;
    op_valid = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    chk("busy_before_cancel", {63'd0, busy}, 64'd1);
    cancel = 1'b1;
    @(posedge clock); #1;
    cancel = 1'b0;
    chk("cancel_busy", {63'd0, busy}, 64'd0);
    chk("cancel_hilo", r_data, model_hilo);
    chk("cancel_nodone", 64'(done_cnt), 64'(dc));
    run_op(3'd1, 32'd3, 32'd5, 64'd15);

    // Direct HI write in the FIX cycle overrides the engine result
    op_valid = 1'b1; op_code = 3'd0; op_a = 32'd2; op_b = 32'd3;
    @(posedge clock); #1;
    op_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("fix_done", {63'd0, done}, 64'd1);
    w_hi = 1'b1; hi_data = 32'h0000_AAAA;
    #1;
    chk("fix_fwd", r_data, 64'h0000_AAAA_0000_0006);
    @(posedge clock); #1;
    w_hi = 1'b0;
    chk("fix_after", r_data, 64'h0000_AAAA_0000_0006);
    model_hilo = 64'h0000_AAAA_0000_0006;

    // Cancel with op_valid in IDLE: not accepted
    dc = done_cnt;
    op_valid = 1'b1; cancel = 1'b1; op_code = 3'd0; op_a = 32'd9; op_b = 32'd9;
    @(posedge clock); #1;
    op_valid = 1'b0; cancel = 1'b0;
    chk("cancel_idle_busy", {63'd0, busy}, 64'd0);
    repeat (5) @(posedge clock);
    #1;
    chk("cancel_idle_nodone", 64'(done_cnt), 64'(dc));
    r_hilo = 1'b0;
    #1;
    chk("rd_disabled", r_data, 64'd0);
    r_hilo = 1'b1;
    #1;
    chk("rd_hilo", r_data, model_hilo);

    // Random ops against the model
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : $urandom;
      run_op(rop, ra, rb, model(rop, ra, rb, model_hilo));
    end

    // Reset in the middle of a DIV
    mt(32'h1234_5678, 32'h9ABC_DEF0);
    op_valid = 1'b1; op_code = 3'd2; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clock); #1;
    op_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    dc = done_cnt;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_data", r_data, 64'd0);
    repeat (40) @(posedge clock);
    #1;
    chk("midrst_nodone", 64'(done_cnt), 64'(dc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
